alu_shift_unit: RTL and testbench

- Parametrised, pipelined barrel shift/rotate unit for the CPU datapath ALU; successor to the single-cycle 32-bit rotate-right block.
- Supports five operations: rotate right, rotate left, logical shift right, logical shift left, arithmetic shift right.
- Generic WIDTH and configurable pipeline depth.
- Valid/ready handshake on input and output so the control unit can issue and stall.

---
 rtl/alu_shift_pkg.sv | 28 ++
 rtl/alu_shift_stage.sv | 68 ++++++
 rtl/alu_shift_unit.sv | 94 +++++++++
 tb/tb_alu_shift_unit.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/alu_shift_pkg.sv
// alu_shift_pkg: op codes and pipeline level-distribution helpers for alu_shift_unit
package alu_shift_pkg;

    typedef enum logic [2:0] {
        OP_ROR = 3'b000,
        OP_ROL = 3'b001,
        OP_SHR = 3'b010,
        OP_SHL = 3'b011,
        OP_SRA = 3'b100
    } op_e;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Number of mux levels handled by stage s; earlier stages absorb the remainder.
    function automatic int lvl_cnt(input int levels, input int stages, input int s);
        return levels / stages + ((s < levels % stages) ? 1 : 0);
    endfunction

    // First mux level handled by stage s.
    function automatic int lvl_lo(input int levels, input int stages, input int s);
        return s * (levels / stages) + ((s < levels % stages) ? s : levels % stages);
    endfunction

endpackage

// File: rtl/alu_shift_stage.sv
// alu_shift_stage: one register stage applying mux levels LO..LO+N-1; flags with ALU_SHIFT_FLAGS_EN
module alu_shift_stage import alu_shift_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int LW    = 5,
    parameter int LO    = 0,
    parameter int N     = 1
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             en,
    input  logic             valid,
    input  op_e              op,
    input  logic [LW-1:0]    amt,
    input  logic             fill,
    input  logic [WIDTH-1:0] data,
`ifdef ALU_SHIFT_FLAGS_EN
    input  logic             carry,
    output logic             carry_q,
    output logic             zero_q,
`endif
    output logic             valid_q,
    output op_e              op_q,
    output logic [LW-1:0]    amt_q,
    output logic             fill_q,
    output logic [WIDTH-1:0] data_q
);

    logic [WIDTH-1:0] x;

    function automatic logic [WIDTH-1:0] lvl(input logic [WIDTH-1:0] v, input int s, input op_e o, input logic f);
        return o == OP_SHL ? v << s :
               o == OP_ROR ? (v >> s) | (v << (WIDTH - s)) :
               (v >> s) | ({WIDTH{f}} & ~({WIDTH{1'b1}} >> s));
    endfunction

    // Apply this stage's levels; amt bit j is the remaining bit for level LO+j.
    always_comb begin
        x = data;
        for (int j = 0; j < N; j++)
            if (amt[j]) x = lvl(x, 1 << (LO + j), op, fill);
    end

    // Stage register; consumed amount bits are dropped so the next stage sees its own at bit 0.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            valid_q <= 1'b0;
            op_q    <= OP_ROR;
            amt_q   <= '0;
            fill_q  <= 1'b0;
            data_q  <= '0;
`ifdef ALU_SHIFT_FLAGS_EN
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
`endif
        end else if (en) begin
            valid_q <= valid;
            op_q    <= op;
            amt_q   <= amt >> N;
            fill_q  <= fill;
            data_q  <= x;
`ifdef ALU_SHIFT_FLAGS_EN
            carry_q <= carry;
            zero_q  <= x == '0;
`endif
        end
    end

endmodule

// File: rtl/alu_shift_unit.sv
// alu_shift_unit: pipelined barrel shift/rotate with valid/ready; ALU_SHIFT_FLAGS_EN adds out_c/out_z
module alu_shift_unit import alu_shift_pkg::*; #(
    parameter int WIDTH       = 32,
    parameter int PIPE_STAGES = 2
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_r
`ifdef ALU_SHIFT_FLAGS_EN
    ,
    output logic             out_c,
    output logic             out_z
`endif
);

    localparam int LW = clog2(WIDTH);
    localparam int P  = PIPE_STAGES;

    logic             stall;
    logic             legal;
    logic [LW-1:0]    b_amt;
    logic [LW-1:0]    neg_amt;
    logic             unused_b;
    logic             v    [P+1];
    op_e              op   [P+1];
    logic [LW-1:0]    amt  [P+1];
    logic             fill [P+1];
    logic [WIDTH-1:0] d    [P+1];

    assign unused_b = ^in_b[WIDTH-1:LW];
    assign b_amt    = in_b[LW-1:0];
    assign neg_amt  = ~b_amt + LW'(1);
    assign legal    = in_op <= OP_SRA;

    // Global stall: every stage freezes while the result waits for the consumer.
    assign stall     = v[P] && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = v[P];
    assign out_r     = d[P];

    // ROL becomes ROR by the complementary amount; illegal ops pass through as ROR by 0.
    assign v[0]    = in_valid && in_ready;
    assign op[0]   = (in_op == OP_ROL || !legal) ? OP_ROR : op_e'(in_op);
    assign amt[0]  = !legal ? '0 : in_op == OP_ROL ? neg_amt : b_amt;
    assign fill[0] = in_op == OP_SRA && in_a[WIDTH-1];
    assign d[0]    = in_a;

`ifdef ALU_SHIFT_FLAGS_EN
    logic c  [P+1];
    logic zv [P];

    // The last bit out is known up front from the original amount, so it just rides along.
    assign c[0]  = (!legal || b_amt == '0) ? 1'b0 :
                   (in_op == OP_ROL || in_op == OP_SHL) ? in_a[neg_amt] : in_a[b_amt - LW'(1)];
    assign out_c = c[P];
    assign out_z = zv[P-1];
`endif

    for (genvar i = 0; i < P; i++) begin : g_stage
        alu_shift_stage #(
            .WIDTH (WIDTH),
            .LW    (LW),
            .LO    (lvl_lo(LW, P, i)),
            .N     (lvl_cnt(LW, P, i))
        ) u_stage (
            .clock   (clock),
            .clear_n (clear_n),
            .en      (!stall),
            .valid   (v[i]),
            .op      (op[i]),
            .amt     (amt[i]),
            .fill    (fill[i]),
            .data    (d[i]),
`ifdef ALU_SHIFT_FLAGS_EN
            .carry   (c[i]),
            .carry_q (c[i+1]),
            .zero_q  (zv[i]),
`endif
            .valid_q (v[i+1]),
            .op_q    (op[i+1]),
            .amt_q   (amt[i+1]),
            .fill_q  (fill[i+1]),
            .data_q  (d[i+1])
        );
    end

endmodule

// File: tb/tb_alu_shift_unit.sv
// tb_alu_shift_unit: directed checks of alu_shift_unit (WIDTH=32, PIPE_STAGES=2)
module tb_alu_shift_unit;
    import alu_shift_pkg::*;

    logic        clock = 1'b0;
    logic        clear_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_r;
`ifdef ALU_SHIFT_FLAGS_EN
    logic        out_c;
    logic        out_z;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] exp_strm [8] = '{32'h12345678, 32'h81234567, 32'h78123456, 32'h67812345,
                                  32'h56781234, 32'h45678123, 32'h34567812, 32'h23456781};

    alu_shift_unit #(.WIDTH(32), .PIPE_STAGES(2)) dut (
        .clock     (clock),
        .clear_n   (clear_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r)
`ifdef ALU_SHIFT_FLAGS_EN
        ,
        .out_c     (out_c),
        .out_z     (out_z)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // One item with out_ready=1: not valid after 1 cycle, valid with result after 2.
    task automatic one(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        @(negedge clock);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
        @(negedge clock);
        in_valid = 1'b0;
        check({tag, "_lat"}, out_valid, 0);
        @(negedge clock);
        check({tag, "_v"}, out_valid, 1);
        check(tag, out_r, exp);
    endtask

    initial begin
        int sent = 0;
        int got  = 0;
        logic acc = 1'b0;
        clear_n = 1'b0; in_valid = 1'b0; in_op = 3'b000; in_a = '0; in_b = '0; out_ready = 1'b1;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_r", out_r, 0);
        check("rst_ready", in_ready, 1);
        repeat (2) @(negedge clock);
        clear_n = 1'b1;

        one("ror1",    OP_ROR, 32'h00000001, 32'd1,  32'h80000000);
        one("ror33",   OP_ROR, 32'h00000001, 32'd33, 32'h80000000);
        one("rol4",    OP_ROL, 32'h80000000, 32'd4,  32'h00000008);
        one("rol8",    OP_ROL, 32'h12345678, 32'd8,  32'h34567812);
        one("rol1",    OP_ROL, 32'h80000001, 32'd1,  32'h00000003);
        one("shl31",   OP_SHL, 32'hFFFFFFFF, 32'd31, 32'h80000000);
        one("shr31",   OP_SHR, 32'h80000000, 32'd31, 32'h00000001);
        one("sra31",   OP_SRA, 32'h80000000, 32'd31, 32'hFFFFFFFF);
        one("sra4n",   OP_SRA, 32'hF0000000, 32'd4,  32'hFF000000);
        one("sra4p",   OP_SRA, 32'h40000000, 32'd4,  32'h04000000);
        one("shr4",    OP_SHR, 32'hF0000000, 32'd4,  32'h0F000000);
        one("ror0",    OP_ROR, 32'hA5A51234, 32'd0,  32'hA5A51234);
        one("rol0",    OP_ROL, 32'hA5A51234, 32'd0,  32'hA5A51234);
        one("shl0",    OP_SHL, 32'hA5A51234, 32'd0,  32'hA5A51234);
        one("sra0",    OP_SRA, 32'hA5A51234, 32'd0,  32'hA5A51234);
        one("shl32",   OP_SHL, 32'h00000001, 32'd32, 32'h00000001);
        one("ill5",    3'b101, 32'hDEADBEEF, 32'd5,  32'hDEADBEEF);
        one("ill7",    3'b111, 32'hDEADBEEF, 32'd9,  32'hDEADBEEF);

`ifdef ALU_SHIFT_FLAGS_EN
        one("f_shr", OP_SHR, 32'h00000003, 32'd1, 32'h00000001);
        check("f_shr_c", out_c, 1);
        check("f_shr_z", out_z, 0);
        one("f_shl", OP_SHL, 32'h80000000, 32'd1, 32'h00000000);
        check("f_shl_c", out_c, 1);
        check("f_shl_z", out_z, 1);
        one("f_rol", OP_ROL, 32'h00000010, 32'd28, 32'h00000001);
        check("f_rol_c", out_c, 1);
        one("f_ror0", OP_ROR, 32'h00000001, 32'd0, 32'h00000001);
        check("f_ror0_c", out_c, 0);
`endif

        // Back-to-back stream: results on 8 consecutive cycles, in order.
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (i >= 2) begin
                check("strm_v", out_valid, 1);
                check("strm", out_r, exp_strm[i-2]);
            end
            in_valid = i < 8; in_op = OP_ROR; in_a = 32'h12345678; in_b = 32'(4 * i);
        end
        @(negedge clock);
        in_valid = 1'b0;
        check("strm_end", out_valid, 0);

        // Stall for 3 cycles mid-stream: inputs blocked, output held, nothing lost or doubled.
        for (int cyc = 0; cyc < 14; cyc++) begin
            @(negedge clock);
            if (acc) sent++;
            in_valid = sent < 4; in_op = OP_ROR; in_a = 32'h12345678; in_b = 32'(4 * sent);
            out_ready = !(cyc >= 4 && cyc <= 6);
            #1;
            if (cyc >= 4 && cyc <= 6) begin
                check("stall_rdy", in_ready, 0);
                check("stall_v", out_valid, 1);
                check("stall_hold", out_r, exp_strm[2]);
            end
            if (out_valid && out_ready) begin
                check("stall_ord", out_r, exp_strm[got & 7]);
                got++;
            end
            acc = in_valid && in_ready;
        end
        in_valid = 1'b0;
        check("stall_got", got, 4);
        check("stall_sent", sent, 4);

        // Reset with two items in flight discards both.
        @(negedge clock);
        in_valid = 1'b1; in_op = OP_ROR; in_a = 32'h1; in_b = 32'd1;
        @(negedge clock);
        in_a = 32'h2;
        @(negedge clock);
        in_valid = 1'b0;
        clear_n = 1'b0;
        #1;
        check("mid_rst_v", out_valid, 0);
        check("mid_rst_r", out_r, 0);
        @(negedge clock);
        clear_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("post_rst_v", out_valid, 0);
        end
        one("post_rst_new", OP_SHR, 32'h00000100, 32'd4, 32'h00000010);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
